// File: rtl/min_delay_sched.sv
// Round-robin scheduler feeding one launch (net1) / capture (port2) register pair
// with a fixed MIN_CYC-edge hold. Optional launch counter under SCHED_STATS_EN.
module min_delay_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int MIN_CYC = 3,
    parameter int CNT_W   = 4
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    launch,
    output logic [DW-1:0]           net1,
    output logic                    capture,
    output logic [DW-1:0]           port2,
    output logic [$clog2(NREQ)-1:0] port2_src,
    output logic                    busy
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]             launch_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   src;
    logic [CNT_W-1:0] cnt;

    logic            found;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   nxt_ptr;
    int unsigned     j;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
        nxt_ptr = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (found) state_n = HOLD;
            HOLD: if (cnt == CNT_W'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            launch    <= 1'b0;
            capture   <= 1'b0;
            net1      <= '0;
            port2     <= '0;
            port2_src <= '0;
            ptr       <= '0;
            src       <= '0;
            cnt       <= '0;
        end else begin
            gnt     <= '0;
            launch  <= 1'b0;
            capture <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    gnt    <= NREQ'(1) << sel;
                    launch <= 1'b1;
                    net1   <= req_data[sel*DW +: DW];
                    src    <= sel;
                    ptr    <= nxt_ptr;
                    cnt    <= CNT_W'(MIN_CYC);
                end
            end else begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    port2     <= net1;
                    port2_src <= src;
                    capture   <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == HOLD);

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)                   launch_cnt <= '0;
        else if (state == IDLE && found) launch_cnt <= launch_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_min_delay_sched.sv
// Self-checking bench for min_delay_sched: edge-timed transfer model plus directed
// literal checks and a randomized phase. Honours SCHED_STATS_EN when defined.
module tb_min_delay_sched;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int MIN_CYC = 3;
    localparam int CNT_W   = 4;
    localparam int PW      = $clog2(NREQ);

    logic                 clk1 = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      gnt;
    logic                 launch;
    logic [DW-1:0]        net1;
    logic                 capture;
    logic [DW-1:0]        port2;
    logic [PW-1:0]        port2_src;
    logic                 busy;
`ifdef SCHED_STATS_EN
    logic [15:0]          launch_cnt;
`endif

    min_delay_sched #(.NREQ(NREQ), .DW(DW), .MIN_CYC(MIN_CYC), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .launch(launch), .net1(net1), .capture(capture),
        .port2(port2), .port2_src(port2_src), .busy(busy)
`ifdef SCHED_STATS_EN
        , .launch_cnt(launch_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int failures = 0;

    // Model: a transfer is described only by its launch edge, word and source.
    int   n;
    int   tl;
    bit   have;
    int   m_word;
    int   m_src;
    int   m_ptr;
    int   m_launches;
    int   e_gnt, e_launch, e_cap, e_busy, e_net1, e_port2, e_src;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; tl = 0; have = 0; m_word = 0; m_src = 0; m_ptr = 0; m_launches = 0;
        e_gnt = 0; e_launch = 0; e_cap = 0; e_busy = 0; e_net1 = 0; e_port2 = 0; e_src = 0;
    endtask

    task automatic step();
        int j;
        bit f;
        @(posedge clk1);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!have || n > tl + MIN_CYC) begin
                f = 0;
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (!f && req[j]) begin
                        f = 1;
                        tl = n; have = 1;
                        m_word = int'(req_data[j*DW +: DW]);
                        m_src = j;
                        m_ptr = (j + 1) % NREQ;
                        m_launches++;
                    end
                end
            end
            e_gnt    = (have && n == tl) ? (1 << m_src) : 0;
            e_launch = (have && n == tl) ? 1 : 0;
            e_busy   = (have && n >= tl && n < tl + MIN_CYC) ? 1 : 0;
            e_cap    = (have && n == tl + MIN_CYC) ? 1 : 0;
            if (e_cap != 0) begin
                e_port2 = m_word;
                e_src   = m_src;
            end
            e_net1 = have ? m_word : 0;
            n++;
        end
        #1;
        check("gnt",       32'(gnt),       32'(e_gnt));
        check("launch",    32'(launch),    32'(e_launch));
        check("capture",   32'(capture),   32'(e_cap));
        check("busy",      32'(busy),      32'(e_busy));
        check("net1",      32'(net1),      32'(e_net1));
        check("port2",     32'(port2),     32'(e_port2));
        check("port2_src", 32'(port2_src), 32'(e_src));
`ifdef SCHED_STATS_EN
        check("launch_cnt", 32'(launch_cnt), 32'(m_launches % 65536));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        req = '0;
        step();
        step();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single request, word 0xA5 from requester 2.
        req = 4'b0100;
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        step();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_launch", 32'(launch), 32'h1);
        req = '0;
        step(); step(); step();
        check("t1_capture", 32'(capture), 32'h1);
        check("t1_port2", 32'(port2), 32'hA5);
        check("t1_src", 32'(port2_src), 32'h2);
        check("t1_busy", 32'(busy), 32'h0);

        // All requesting: grants 0,1,2,3,0 at edges 0,4,8,12,16.
        do_reset();
        req = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int e = 0; e <= 16; e++) begin
            step();
            if (e % 4 == 0) check("t2_gnt", 32'(gnt), 32'(1 << ((e / 4) % 4)));
            if (e % 4 == 3) check("t2_port2", 32'(port2), 32'(8'h10 + (e / 4) % 4));
        end
`ifdef SCHED_STATS_EN
        check("t2_launch_cnt", 32'(launch_cnt), 32'd5);
`endif
        req = '0;
        step(); step(); step();

        // Wrap: grant 2 leaves ptr=3, then 4'b1001 grants 3 before 0.
        do_reset();
        req = 4'b0100;
        step();
        req = '0;
        step(); step(); step();
        req = 4'b1001;
        step();
        check("t3_gnt_a", 32'(gnt), 32'h8);
        step(); step(); step(); step();
        check("t3_gnt_b", 32'(gnt), 32'h1);
        req = '0;
        step(); step(); step();

        // Data changes while holding: net1/port2 keep the sampled word.
        do_reset();
        req = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        step();
        req = '0;
        step();
        req_data = '1;
        step();
        check("t4_net1", 32'(net1), 32'h5A);
        step();
        check("t4_capture", 32'(capture), 32'h1);
        check("t4_port2", 32'(port2), 32'h5A);

        // Reset mid-transfer: outputs clear at once, transfer discarded.
        do_reset();
        req = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h3C, 8'h77};
        step();
        req = '0;
        step();
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", 32'({gnt, launch, capture, busy, net1, port2, port2_src}), 32'h0);
        step();
        check("t5_no_capture", 32'(capture), 32'h0);
        step();
        @(negedge clk1);
        rst_n = 1'b1;
        req = 4'b0010;
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        check("t5_net1", 32'(net1), 32'h3C);
        req = '0;
        step(); step(); step();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req = NREQ'($urandom);
            req_data = (NREQ*DW)'($urandom);
            if ($urandom_range(0, 249) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
